// File: rtl/flow_verdict_pkg.sv
// flow_verdict_stream shared types and sizes.
// Batch geometry, FSM states and flow-count saturation.
package flow_verdict_pkg;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 4;
  localparam int FLOW_ID_W = 8;
  localparam int MAX_FLOWS = WORD_W * NUM_WORDS;
  localparam int BIT_W     = $clog2(WORD_W);
  localparam int WCNT_W    = $clog2(NUM_WORDS);
  localparam int CNT_W     = FLOW_ID_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  // Clamp the requested flow count to the bitmap size.
  function automatic logic [CNT_W-1:0] sat_flows(
    input logic [15:0] n
  );
    if (n > 16'(MAX_FLOWS)) return CNT_W'(MAX_FLOWS);
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/flow_verdict_stream_if.sv
// Result-word input and verdict stream bundle.
// slave is the converter side, master the driver/consumer side.
interface flow_verdict_stream_if;
  import flow_verdict_pkg::*;

  logic [WORD_W-1:0]    i_result;
  logic                 i_result_valid;
  logic [15:0]          i_flow_num;
  logic                 i_verdict_ready;
  logic                 o_verdict_valid;
  logic [FLOW_ID_W-1:0] o_verdict_flow_id;
  logic                 o_verdict_enc;
  logic                 o_batch_done;
  logic [FLOW_ID_W:0]   o_enc_count;
  logic                 o_overrun;

  modport master (
    output i_result,
    output i_result_valid,
    output i_flow_num,
    output i_verdict_ready,
    input  o_verdict_valid,
    input  o_verdict_flow_id,
    input  o_verdict_enc,
    input  o_batch_done,
    input  o_enc_count,
    input  o_overrun
  );

  modport slave (
    input  i_result,
    input  i_result_valid,
    input  i_flow_num,
    input  i_verdict_ready,
    output o_verdict_valid,
    output o_verdict_flow_id,
    output o_verdict_enc,
    output o_batch_done,
    output o_enc_count,
    output o_overrun
  );

endinterface

// File: rtl/flow_verdict_buf.sv
// Result bitmap store: word-wide writes,
// single-bit read selected by flow index.
module flow_verdict_buf
  import flow_verdict_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [WCNT_W-1:0]    waddr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [FLOW_ID_W-1:0] ridx,
  output logic                 rbit
);

  logic [WORD_W-1:0] mem [NUM_WORDS];

  // Capture one result word per write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rbit = mem[ridx[FLOW_ID_W-1:BIT_W]][ridx[BIT_W-1:0]];

endmodule

// File: rtl/flow_verdict_stream.sv
// Bitmap-to-verdict converter: collects result words,
// streams one verdict per flow, counts encrypted flows.
module flow_verdict_stream
  import flow_verdict_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst_n,
  flow_verdict_stream_if.slave bus
);

  state_t               state;
  logic [WCNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]     n_flows;
  logic [CNT_W-1:0]     run_cnt;
  logic [FLOW_ID_W-1:0] idx;
  logic                 verdict_valid;
  logic                 batch_done;
  logic [CNT_W-1:0]     enc_count;
  logic                 overrun;

  logic                 buf_we;
  logic [WCNT_W-1:0]    buf_addr;
  logic                 buf_bit;
  logic                 fire;
  logic                 last;
  logic                 last_word;

  assign buf_we = bus.i_result_valid
                & ((state == IDLE) | (state == COLLECT));
  assign buf_addr = (state == IDLE) ? '0 : word_cnt;

  flow_verdict_buf u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (bus.i_result),
    .ridx  (idx),
    .rbit  (buf_bit)
  );

  assign fire = verdict_valid & bus.i_verdict_ready;
  assign last = ({1'b0, idx} == n_flows - CNT_W'(1));
  assign last_word = (word_cnt == WCNT_W'(NUM_WORDS - 1));

  // Batch FSM with registered handshake, done and count outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      word_cnt      <= '0;
      n_flows       <= '0;
      run_cnt       <= '0;
      idx           <= '0;
      verdict_valid <= 1'b0;
      batch_done    <= 1'b0;
      enc_count     <= '0;
      overrun       <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_result_valid) begin
            word_cnt <= WCNT_W'(1);
            n_flows  <= sat_flows(bus.i_flow_num);
            run_cnt  <= '0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.i_result_valid) begin
            if (last_word) begin
              word_cnt <= '0;
              if (n_flows != '0) begin
                verdict_valid <= 1'b1;
                state         <= DRAIN;
              end else begin
                batch_done <= 1'b1;
                enc_count  <= run_cnt;
                state      <= DONE;
              end
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.i_result_valid) overrun <= 1'b1;
          if (fire) begin
            run_cnt <= run_cnt + CNT_W'(buf_bit);
            if (last) begin
              verdict_valid <= 1'b0;
              batch_done    <= 1'b1;
              enc_count     <= run_cnt + CNT_W'(buf_bit);
              state         <= DONE;
            end else begin
              idx <= idx + FLOW_ID_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.i_result_valid) overrun <= 1'b1;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_verdict_valid   = verdict_valid;
  assign bus.o_verdict_flow_id = idx;
  assign bus.o_verdict_enc     = verdict_valid & buf_bit;
  assign bus.o_batch_done      = batch_done;
  assign bus.o_enc_count       = enc_count;
  assign bus.o_overrun         = overrun;

endmodule

// File: tb/tb_flow_verdict_stream.sv
// Bench for flow_verdict_stream: per-batch verdict
// queue model, per-cycle compare, directed batches.
module tb_flow_verdict_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  flow_verdict_stream_if bus ();

  flow_verdict_stream dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int id;
    int enc;
  } vd_t;

  typedef struct {
    int cnt;
    int n;
  } bt_t;

  vd_t exp_q[$];
  bt_t bat_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fire_cyc = -10;
  int batch_fires = 0;
  int last_fires = 0;
  int done_seen = 0;
  int ready_mode = 0;

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_id = '0;
  logic       prev_enc = 1'b0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Consumer ready: always high, or a pseudo-random pattern.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) bus.i_verdict_ready = 1'b1;
    else bus.i_verdict_ready = ($urandom_range(0, 1) != 0);
  end

  // Per-cycle compare against the verdict queue model.
  always @(negedge clk) begin
    bt_t b;
    cyc++;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid", bus.o_verdict_valid, 1);
        check("stall_id", bus.o_verdict_flow_id, prev_id);
        check("stall_enc", bus.o_verdict_enc, prev_enc);
      end
      if (bus.o_verdict_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_verdict", 1, 0);
        end else begin
          check("flow_id", bus.o_verdict_flow_id, exp_q[0].id);
          check("enc", bus.o_verdict_enc, exp_q[0].enc);
          if (bus.i_verdict_ready) begin
            void'(exp_q.pop_front());
            batch_fires++;
            last_fire_cyc = cyc;
          end
        end
      end
      if (bus.o_batch_done) begin
        check("done_single", prev_done, 0);
        if (bat_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          b = bat_q.pop_front();
          check("left_over", exp_q.size(), 0);
          check("enc_count", bus.o_enc_count, b.cnt);
          check("fire_count", batch_fires, b.n);
          if (b.n > 0) check("done_latency", cyc, last_fire_cyc + 1);
        end
        last_fires  = batch_fires;
        batch_fires = 0;
        done_seen++;
      end
      prev_valid = bus.o_verdict_valid;
      prev_ready = bus.i_verdict_ready;
      prev_id    = bus.o_verdict_flow_id;
      prev_enc   = bus.o_verdict_enc;
      prev_done  = bus.o_batch_done;
    end
  end

  task automatic send_batch(input logic [63:0] w0,
                            input logic [63:0] w1,
                            input logic [63:0] w2,
                            input logic [63:0] w3,
                            input int fn);
    logic [63:0] w[4];
    int n;
    int cnt;
    vd_t v;
    bt_t b;
    w = '{w0, w1, w2, w3};
    n = (fn > 256) ? 256 : fn;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      v.id  = i;
      v.enc = int'(w[i / 64][i % 64]);
      exp_q.push_back(v);
      cnt += v.enc;
    end
    b.cnt = cnt;
    b.n   = n;
    bat_q.push_back(b);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      bus.i_result       = w[k];
      bus.i_result_valid = 1'b1;
      bus.i_flow_num     = 16'(fn);
      @(posedge clk);
      #1;
    end
    bus.i_result_valid = 1'b0;
    @(negedge clk);
    check("first_valid", bus.o_verdict_valid, (n > 0) ? 1 : 0);
    if (n > 0) check("first_id", bus.o_verdict_flow_id, 0);
    else check("zero_done", bus.o_batch_done, 1);
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_seen;
    for (int i = 0; i < budget && done_seen == start; i++) begin
      @(negedge clk);
    end
    if (done_seen == start) check("done_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus.o_verdict_valid, 0);
    check({tag, "_id"}, bus.o_verdict_flow_id, 0);
    check({tag, "_enc"}, bus.o_verdict_enc, 0);
    check({tag, "_done"}, bus.o_batch_done, 0);
    check({tag, "_count"}, bus.o_enc_count, 0);
    check({tag, "_overrun"}, bus.o_overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_result       = '0;
    bus.i_result_valid = 1'b0;
    bus.i_flow_num     = '0;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    ready_mode = 0;
    send_batch(64'h1, 64'h0, 64'h0,
               64'h8000_0000_0000_0000, 256);
    wait_done(400);
    check("t1_count", bus.o_enc_count, 2);
    check("t1_fires", last_fires, 256);

    send_batch('1, '1, '1, '1, 70);
    wait_done(200);
    check("t2_count", bus.o_enc_count, 70);
    check("t2_fires", last_fires, 70);

    ready_mode = 1;
    send_batch(64'h0123_4567_89AB_CDEF,
               64'hFEDC_BA98_7654_3210,
               64'hDEAD_BEEF_CAFE_F00D,
               64'h1, 200);
    wait_done(3000);
    check("t3_count", bus.o_enc_count, 107);
    check("t3_fires", last_fires, 200);
    ready_mode = 0;

    send_batch('1, '1, '1, '1, 0);
    wait_done(10);
    check("t4_count", bus.o_enc_count, 0);

    send_batch('1, '1, '1, '1, 1000);
    wait_done(400);
    check("t5_count", bus.o_enc_count, 256);
    check("t5_fires", last_fires, 256);

    check("overrun_clear", bus.o_overrun, 0);
    send_batch({4{16'hAAAA}}, {4{16'hAAAA}},
               {4{16'hAAAA}}, {4{16'hAAAA}}, 100);
    repeat (10) @(posedge clk);
    #1;
    bus.i_result       = '1;
    bus.i_result_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_result_valid = 1'b0;
    check("overrun_set", bus.o_overrun, 1);
    wait_done(200);
    check("t6_count", bus.o_enc_count, 50);
    check("overrun_sticky", bus.o_overrun, 1);
    send_batch(64'h1, 64'h0, 64'h0, 64'h0, 64);
    wait_done(200);
    check("t6b_count", bus.o_enc_count, 1);
    check("overrun_held", bus.o_overrun, 1);

    send_batch('1, '1, '1, '1, 256);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    bat_q.delete();
    batch_fires = 0;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_batch({4{16'h5555}}, {4{16'h5555}},
               {4{16'h5555}}, {4{16'h5555}}, 256);
    wait_done(400);
    check("t7_count", bus.o_enc_count, 128);
    check("t7_fires", last_fires, 256);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
